// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle of hazard-detection inputs and pipeline-control outputs
// exchanged between the pipeline datapath and the pipe_ctrl hazard unit.
//
// Signals (from the datapath's point of view):
//   id_rs1/id_rs2, id_rs1_en/id_rs2_en  source registers of the ID instruction
//   ex_rd, ex_mem_read                  destination / load flag of the EX instruction
//   ex_br_taken, ex_br_target           redirect request resolved in EX
//   mem_busy                            data memory not ready, whole pipe holds
//   stall_if, stall_id_reg              hold PC / hold if_id register
//   invalid                             zero the if_id register
//   bubble_ex                           insert a NOP into id_ex
//   redirect_valid, redirect_pc         load redirect_pc into the PC
//
// Modports: master = pipeline datapath, slave = pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_en;
  logic              id_rs2_en;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_br_taken;
  logic [WIDTH-1:0]  ex_br_target;
  logic              mem_busy;
  logic              stall_if;
  logic              stall_id_reg;
  logic              invalid;
  logic              bubble_ex;
  logic              redirect_valid;
  logic [WIDTH-1:0]  redirect_pc;

  modport master (
    output id_rs1, id_rs2, id_rs1_en, id_rs2_en, ex_rd, ex_mem_read,
           ex_br_taken, ex_br_target, mem_busy,
    input  stall_if, stall_id_reg, invalid, bubble_ex, redirect_valid, redirect_pc
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_en, id_rs2_en, ex_rd, ex_mem_read,
           ex_br_taken, ex_br_target, mem_busy,
    output stall_if, stall_id_reg, invalid, bubble_ex, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard and redirect controller.
//
// Resolves, in priority order, a memory hold (mem_busy), a control redirect
// from EX and a load-use hazard between EX and ID. A redirect invalidates the
// if_id register for FLUSH_CYCLES consecutive cycles. A redirect arriving
// while the memory holds the pipe is parked in pend_v/pend_pc (first one
// wins) and issued as soon as the hold releases. All control outputs are
// combinational from the current state and the inputs.
//
// Ports:
//   sys_clk         sole clock, rising edge
//   sys_rst         asynchronous active-low reset; forces all outputs to 0
//   bus             pipe_ctrl_if.slave: hazard inputs and control outputs
//   perf_stall_cnt  (PIPE_CTRL_PERF_EN only) cycles with stall_if=1
//   perf_flush_cnt  (PIPE_CTRL_PERF_EN only) cycles with redirect_valid=1
//
// Optional feature: define PIPE_CTRL_PERF_EN to add the two 32-bit
// wrapping performance counters.
module pipe_ctrl #(
  parameter int WIDTH        = 32,
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  pipe_ctrl_if.slave     bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]    perf_stall_cnt,
  output logic [31:0]    perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // The redirect cycle itself is the first invalid cycle, so FLUSH covers
  // the remaining FLUSH_CYCLES-1.
  localparam logic [2:0] FLUSH_INIT  = 3'(FLUSH_CYCLES - 1);
  localparam logic       FLUSH_MULTI = (FLUSH_CYCLES > 1) ? 1'b1 : 1'b0;

  state_t           state;
  state_t           state_n;
  logic             pend_v;
  logic             pend_v_n;
  logic [WIDTH-1:0] pend_pc;
  logic [WIDTH-1:0] pend_pc_n;
  logic [2:0]       cnt;
  logic [2:0]       cnt_n;

  logic             lu;
  logic             redir_req;
  logic [WIDTH-1:0] redir_tgt;

  // Hazard decode: load-use detection and the effective redirect source.
  always_comb begin
    lu = bus.ex_mem_read & (bus.ex_rd != {REG_AW{1'b0}}) &
         ((bus.id_rs1_en & (bus.id_rs1 == bus.ex_rd)) |
          (bus.id_rs2_en & (bus.id_rs2 == bus.ex_rd)));
    // A parked redirect is older than anything in EX now, so it wins.
    if (pend_v) begin
      redir_req = 1'b1;
      redir_tgt = pend_pc;
    end else begin
      redir_req = bus.ex_br_taken;
      redir_tgt = bus.ex_br_target;
    end
  end

  // State register: FSM state, parked redirect and flush counter.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state   <= RUN;
      pend_v  <= 1'b0;
      pend_pc <= {WIDTH{1'b0}};
      cnt     <= 3'd0;
    end else begin
      state   <= state_n;
      pend_v  <= pend_v_n;
      pend_pc <= pend_pc_n;
      cnt     <= cnt_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n   = state;
    pend_v_n  = pend_v;
    pend_pc_n = pend_pc;
    cnt_n     = cnt;
    case (state)
      RUN, MWAIT, FLUSH: begin
        if (bus.mem_busy) begin
          // Park only the first redirect seen during the hold.
          if (!pend_v && bus.ex_br_taken) begin
            pend_v_n  = 1'b1;
            pend_pc_n = bus.ex_br_target;
          end else begin
            pend_v_n  = pend_v;
            pend_pc_n = pend_pc;
          end
          // FLUSH keeps its place (counter frozen) across a memory hold.
          if (state == FLUSH) begin
            state_n = FLUSH;
          end else begin
            state_n = MWAIT;
          end
        end else if (redir_req) begin
          pend_v_n = 1'b0;
          if (FLUSH_MULTI) begin
            state_n = FLUSH;
            cnt_n   = FLUSH_INIT;
          end else begin
            state_n = RUN;
            cnt_n   = 3'd0;
          end
        end else if (state == FLUSH) begin
          pend_v_n = 1'b0;
          if (cnt <= 3'd1) begin
            state_n = RUN;
            cnt_n   = 3'd0;
          end else begin
            state_n = FLUSH;
            cnt_n   = cnt - 3'd1;
          end
        end else begin
          pend_v_n = 1'b0;
          state_n  = RUN;
        end
      end
      default: begin
        state_n   = RUN;
        pend_v_n  = 1'b0;
        pend_pc_n = {WIDTH{1'b0}};
        cnt_n     = 3'd0;
      end
    endcase
  end

  // Output logic: combinational pipeline controls, all zero during reset.
  always_comb begin
    bus.stall_if       = 1'b0;
    bus.stall_id_reg   = 1'b0;
    bus.invalid        = 1'b0;
    bus.bubble_ex      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = {WIDTH{1'b0}};
    if (!sys_rst) begin
      bus.stall_if = 1'b0;
    end else begin
      case (state)
        RUN, MWAIT, FLUSH: begin
          if (bus.mem_busy) begin
            // Whole-pipe hold; invalid stays low so if_id keeps its content.
            bus.stall_if     = 1'b1;
            bus.stall_id_reg = 1'b1;
          end else if (redir_req) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = redir_tgt;
            bus.invalid        = 1'b1;
            bus.bubble_ex      = 1'b1;
          end else if (state == FLUSH) begin
            // if_id holds wrong-path fetch; a load-use stall is moot here.
            bus.invalid = 1'b1;
          end else if (lu) begin
            bus.stall_if     = 1'b1;
            bus.stall_id_reg = 1'b1;
            bus.bubble_ex    = 1'b1;
          end else begin
            bus.stall_if = 1'b0;
          end
        end
        default: begin
          bus.stall_if = 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Performance counters: stall cycles and redirect cycles, wrapping.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (bus.stall_if) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end else begin
        perf_stall_cnt <= perf_stall_cnt;
      end
      if (bus.redirect_valid) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end else begin
        perf_flush_cnt <= perf_flush_cnt;
      end
    end
  end
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC/target width.
REQ-002 SHALL have parameter REG_AW, default 5, register-index width.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 1, legal 1..7: cycles of if_id invalidation per redirect.
REQ-004 SHALL have ports:
- sys_clk  in  1  sole clock, rising edge.
- sys_rst  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  REG_AW  source indices of the instruction in ID.
- id_rs1_en, id_rs2_en  in  1  source actually read.
- ex_rd  in  REG_AW  destination of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_br_taken  in  1  EX resolved a taken branch/jump.
- ex_br_target  in  WIDTH  redirect address.
- mem_busy  in  1  data memory not ready; whole pipe must hold.
- stall_if  out  1  hold PC.
- stall_id_reg  out  1  hold if_id register.
- invalid  out  1  zero if_id register.
- bubble_ex  out  1  insert NOP into id_ex.
- redirect_valid  out  1  load redirect_pc into PC.
- redirect_pc  out  WIDTH  redirect address.

Function
REQ-005 SHALL implement FSM states RUN, MWAIT, FLUSH, plus pend_v/pend_pc and a 3-bit flush counter as the only state.
REQ-006 SHALL define lu = ex_mem_read & (ex_rd!=0) & ((id_rs1_en & id_rs1==ex_rd) | (id_rs2_en & id_rs2==ex_rd)).
REQ-007 SHALL drive all outputs combinationally from state and inputs (zero latency); unlisted outputs 0; redirect_pc 0 unless redirect_valid.
REQ-008 RUN, mem_busy=1: stall_if=stall_id_reg=1; capture pend_v=1, pend_pc=ex_br_target if ex_br_taken; next MWAIT.
REQ-009 RUN, mem_busy=0, redirect (ex_br_taken): redirect_valid=1, redirect_pc=ex_br_target, invalid=1, bubble_ex=1; next FLUSH with counter=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
REQ-010 RUN, mem_busy=0, no redirect, lu: stall_if=stall_id_reg=bubble_ex=1; stay RUN.
REQ-011 Priority: mem_busy > redirect > lu.
REQ-012 MWAIT, mem_busy=1: stall_if=stall_id_reg=1; capture ex_br_taken into pend only if pend_v=0 (first redirect wins).
REQ-013 MWAIT, mem_busy=0: behave as RUN, with redirect = pend_v | ex_br_taken and target pend_pc when pend_v; clear pend_v.
REQ-014 FLUSH, mem_busy=0: invalid=1; redirect in FLUSH restarts it per REQ-009; else decrement counter, go RUN when counter reaches 1 -> exits after exactly FLUSH_CYCLES invalid cycles total.
REQ-015 FLUSH, mem_busy=1: stall_if=stall_id_reg=1, invalid=0; counter frozen; redirect captured into pend per REQ-012.
REQ-016 invalid and stall_id_reg SHALL never be 1 in the same cycle.

Reset
REQ-017 sys_rst low SHALL asynchronously set state RUN, pend_v=0, pend_pc=0, counter=0.
REQ-018 While sys_rst is low all outputs SHALL be 0; mid-redirect or mid-MWAIT reset SHALL discard pending redirects.

Configuration
REQ-019 With PIPE_CTRL_PERF_EN defined, add outputs perf_stall_cnt[31:0] (cycles with stall_if=1) and perf_flush_cnt[31:0] (cycles with redirect_valid=1), both reset to 0, wrapping at 2^32.
REQ-020 Without PIPE_CTRL_PERF_EN these ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-021 ex_mem_read=1, ex_rd=5, id_rs2=5, id_rs2_en=1 -> one cycle stall_if=stall_id_reg=bubble_ex=1; ex_rd=0 -> no stall.
REQ-022 FLUSH_CYCLES=3, ex_br_taken pulse, target 0x100 -> redirect_valid with 0x100 once, invalid=1 for 3 consecutive cycles, then RUN.
REQ-023 mem_busy high 4 cycles, ex_br_taken (0x200) in cycle 2 then 0x300 in cycle 3 -> 4 stall cycles, no invalid, then redirect to 0x200.
REQ-024 ex_br_taken and lu in same cycle -> redirect only, stall_if=0.
REQ-025 sys_rst low during FLUSH with pend_v=1 -> outputs 0 immediately; after release no redirect issued.
REQ-026 PIPE_CTRL_PERF_EN: 3 load-use stalls + 2 redirects -> perf_stall_cnt=3, perf_flush_cnt=2.
